jt51_lfo_mc: RTL
================

Name: jt51_lfo_mc

Overview:
Multi-channel, parametrised LFO for the JT51 family and derived cores. It is the successor to the single-channel LFO.
- Phase-accumulator based; CH independent channels, each with its own rate, waveform, AM/PM depth and sync reset.
- Depth scaling runs through one shared multiplier pair, time-multiplexed by a channel sequencer.
- Sits beside the envelope/phase generators and feeds per-channel am/pm_u to them.

Parameters:
CH, 2, number of LFO channels (1..32)
PHW, 16, phase accumulator width (>=9)
RW, 8, rate input width per channel (RW<=PHW)
AW, 7, AM depth/output width per channel
PW, 8, PM output width per channel; PM depth input is PW-1 bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cen  in  1  clock enable; all state changes are gated by cen
zero  in  1  LFO tick strobe; tick = cen & zero
lfo_rst  in  CH  per-channel synchronous LFO reset (key sync)
lfo_freq  in  CH*RW  per-channel phase step, channel k at [k*RW +: RW]
lfo_w  in  CH*2  per-channel waveform: 0 saw, 1 square, 2 triangle, 3 noise
lfo_amd  in  CH*AW  per-channel AM depth
lfo_pmd  in  CH*(PW-1)  per-channel PM depth
am  out  CH*AW  per-channel AM value
pm_u  out  CH*PW  per-channel PM value, sign + one's-complement magnitude
wrap  out  CH  one-cen pulse on phase overflow
busy  out  1  sequencer active

Behaviour:
- Reset (rst high, async): all phases 0, held noise samples 0, am=0, pm_u=0, wrap=0, busy=0, LFSR=17'h1, sequencer idle.
- Tick handling:
  - Every channel phase[k] <= phase[k] + zero-extended rate, modulo 2^PHW. Rate 0 freezes the phase.
  - wrap[k]=1 for exactly that cen cycle if the add carried out; otherwise wrap[k]=0 on every cen edge.
- LFSR: 17-bit, shared, shifts once per tick. Feedback = bit16 ^ bit13, shifted into bit0.
- Noise sample-and-hold: on a wrap of channel k, noise[k] <= LFSR[7:0], using the pre-shift value.
- Raw level r (8-bit unsigned), from p = phase[PHW-1 -: 8]:
  - saw: r = p
  - square: r = p[7] ? 8'h00 : 8'hFF
  - triangle: r = p[7] ? ~{p[6:0],1'b0} : {p[6:0],1'b0}
  - noise: r = noise[k]
- Signed level: s = r ^ 8'h80, interpreted as signed (-128..127).
- AM: am[k] = (r * amd[k]) >> 8, truncated to AW.
- PM:
  - pm = (s * pmd[k]) >>> 7, signed PW bits, so s=-128 gives exactly -pmd.
  - If pm < 0: pm_u = {1'b1, ~pm[PW-2:0]}; else pm_u = pm.
- Sequencer states and transitions:
  - IDLE -> RUN on tick. The channel index starts at 0.
  - RUN: each cen cycle processes one channel index i. It computes from the post-tick phase and registers am[i]/pm_u[i], so channel i updates i+1 cen cycles after the tick edge.
  - RUN -> IDLE after channel CH-1. busy=1 exactly while in RUN.
- Tick while busy: phases still advance, and the sequencer restarts at channel 0. Unprocessed channels keep their previous outputs.
- lfo_rst[k] (sampled on cen):
  - Clears phase[k], noise[k], am[k] and pm_u[k] on that edge.
  - Has priority over a simultaneous tick for channel k; wrap[k] stays 0.
  - If the sequencer reaches channel k while lfo_rst[k] is high, its outputs are written 0.
- Input changes:
  - Depth or waveform changes take effect the next time the sequencer processes that channel.
  - Rate changes take effect on the next tick.
- cen low: nothing changes, including wrap and the sequencer.

Test Plan:
- Saw AM (defaults), ch0 lfo_w=0, rate=8'h80, amd=127, pmd=127:
  - After 256 ticks plus sequencer settling, phase=16'h8000, am0=63, pm_u0=8'h00.
  - After 512 ticks, wrap0 pulses once, then am0=0 and pm_u0=8'hFE (pm=-127).
- Square/triangle, ch1 lfo_w=1 then 2, amd=64, rate=8'hFF:
  - Square: am1 alternates between 63 and 0 at half-period boundaries.
  - Triangle: p=8'h40 gives r=8'h80, am1=32.
- Noise, ch0 lfo_w=3, amd=127, rate=8'hFF: am0 changes only on cycles following a wrap0 pulse, and matches (LFSR[7:0]*127)>>8 from a reference LFSR model.
- Key sync: lfo_rst[0] pulsed on the same cen as a tick:
  - phase0 stays 0, wrap0=0, am0=0.
  - Channel 1 advances normally.
- Sequencer, CH=4, ticks 2 cen apart:
  - busy never drops.
  - Only channels 0-1 update; channels 2-3 hold their values.
- Async reset: rst asserted mid-RUN, between cen pulses:
  - All outputs go 0 immediately; busy=0; LFSR returns to 1.

Source files
------------

// File: rtl/jt51_lfo_mc.sv
// jt51_lfo_mc: multi-channel phase-accumulator LFO.
// Every channel advances its phase on each tick. One shared depth-scaling
// datapath is walked across the channels by a small sequencer, so channel i
// refreshes its am/pm_u outputs i+1 enabled cycles after the tick edge.
module jt51_lfo_mc #(
  parameter int CH  = 2,
  parameter int PHW = 16,
  parameter int RW  = 8,
  parameter int AW  = 7,
  parameter int PW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic [CH-1:0]          lfo_rst,
  input  logic [CH*RW-1:0]       lfo_freq,
  input  logic [CH*2-1:0]        lfo_w,
  input  logic [CH*AW-1:0]       lfo_amd,
  input  logic [CH*(PW-1)-1:0]   lfo_pmd,
  output logic [CH*AW-1:0]       am,
  output logic [CH*PW-1:0]       pm_u,
  output logic [CH-1:0]          wrap,
  output logic                   busy
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [16:0]     lfsr_r;
  logic [PHW-1:0]  phase_r [CH];
  logic [7:0]      noise_r [CH];
  logic [PHW:0]    sum_s   [CH];
  logic            tick_s;
  int              sel_s;
  logic [7:0]      level_s;
  logic [AW-1:0]   am_calc_s;
  logic [PW-1:0]   pmu_calc_s;

  // Raw 8-bit unsigned waveform level from the top phase byte
  function automatic logic [7:0] raw_level(input logic [7:0] p, input logic [1:0] w,
                                           input logic [7:0] n);
    case (w)
      2'd0:    raw_level = p;
      2'd1:    raw_level = p[7] ? 8'h00 : 8'hFF;
      2'd2:    raw_level = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      2'd3:    raw_level = n;
      default: raw_level = n;
    endcase
  endfunction

  // Unsigned AM scaling: (r * depth) >> 8
  function automatic logic [AW-1:0] am_scale(input logic [7:0] r, input logic [AW-1:0] d);
    am_scale = AW'(({{AW{1'b0}}, r} * {8'h00, d}) >> 4'd8);
  endfunction

  // Signed PM scaling: s = r ^ 0x80, pm = (s * depth) >>> 7 so s=-128 yields -depth
  function automatic logic [PW-1:0] pm_scale(input logic [7:0] r, input logic [PW-2:0] d);
    logic [7:0] s;
    s = r ^ 8'h80;
    pm_scale = PW'(($signed({{PW{s[7]}}, s}) * $signed({9'd0, d})) >>> 4'd7);
  endfunction

  // Two's complement PM to sign + one's-complement magnitude
  function automatic logic [PW-1:0] pm_to_u(input logic [PW-1:0] pm);
    pm_to_u = pm[PW-1] ? {1'b1, ~pm[PW-2:0]} : pm;
  endfunction

  assign tick_s = cen & zero;

  // Next phase for every channel; the extra MSB is the wrap carry
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      sum_s[k] = {1'b0, phase_r[k]} + (PHW+1)'(lfo_freq[k*RW +: RW]);
    end
  end

  // Shared datapath: level, AM and PM of the channel the sequencer points at
  always_comb begin
    sel_s      = int'(idx_r);
    level_s    = raw_level(phase_r[idx_r][PHW-1 -: 8], lfo_w[sel_s*32'sd2 +: 2], noise_r[idx_r]);
    am_calc_s  = am_scale(level_s, lfo_amd[sel_s*AW +: AW]);
    pmu_calc_s = pm_to_u(pm_scale(level_s, lfo_pmd[sel_s*(PW-1) +: PW-1]));
  end

  // Phase accumulators, wrap pulses, noise sample-and-hold and the shared LFSR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        phase_r[k] <= {PHW{1'b0}};
        noise_r[k] <= 8'h00;
      end
      wrap   <= {CH{1'b0}};
      lfsr_r <= 17'h00001;
    end else if (cen) begin
      for (int k = 0; k < CH; k++) begin
        if (lfo_rst[k]) begin
          phase_r[k] <= {PHW{1'b0}};
          noise_r[k] <= 8'h00;
          wrap[k]    <= 1'b0;
        end else if (tick_s) begin
          phase_r[k] <= sum_s[k][PHW-1:0];
          wrap[k]    <= sum_s[k][PHW];
          if (sum_s[k][PHW]) begin
            noise_r[k] <= lfsr_r[7:0];
          end
        end else begin
          wrap[k] <= 1'b0;
        end
      end
      if (tick_s) begin
        lfsr_r <= {lfsr_r[15:0], lfsr_r[16] ^ lfsr_r[13]};
      end
    end
  end

  // Channel sequencer with registered busy and per-channel am/pm_u outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
      busy    <= 1'b0;
      am      <= {(CH*AW){1'b0}};
      pm_u    <= {(CH*PW){1'b0}};
    end else if (cen) begin
      for (int k = 0; k < CH; k++) begin
        if (lfo_rst[k]) begin
          am[k*AW +: AW]   <= {AW{1'b0}};
          pm_u[k*PW +: PW] <= {PW{1'b0}};
        end else if (state_r == RUN && idx_r == IW'(k)) begin
          am[k*AW +: AW]   <= am_calc_s;
          pm_u[k*PW +: PW] <= pmu_calc_s;
        end
      end
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r <= RUN;
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (tick_s) begin
            idx_r <= {IW{1'b0}};
            busy  <= 1'b1;
          end else if (idx_r == IW'(CH - 1)) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b0;
          end else begin
            idx_r <= idx_r + IW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IW{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
